ulpb_tx_feeder: RTL and testbench

ULPB_TX_FEEDER -- requirements
Module: ulpb_tx_feeder

---
 rtl/ulpb_pkg.sv | 23 ++
 rtl/ulpb_sync_fifo.sv | 78 +++++++
 rtl/ulpb_tx_feeder.sv | 264 ++++++++++++++++++++++++++
 tb/tb_ulpb_tx_feeder.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ulpb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ulpb_pkg
// Brief    : Shared widths and state encoding for the ULPB transmit feeder.
// Revision : 1.0 - initial release
// ============================================================================
package ulpb_pkg;

    localparam int c_ADDR_WIDTH = 8;
    localparam int c_DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD0 = 3'd1,
        ST_LOAD1 = 3'd2,
        ST_REQ   = 3'd3,
        ST_WAIT  = 3'd4,
        ST_DRAIN = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ulpb_sync_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ulpb_sync_fifo
// Brief    : Single-clock FIFO with show-ahead read data, flush and occupancy.
// Revision : 1.0 - initial release
// ============================================================================
module ulpb_sync_fifo #(
    parameter int WIDTH = 41,
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_wr_data,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    localparam int                 c_PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]   c_FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_LAST) ? '0 : p + c_PTR_W'(1);
    endfunction

    assign o_full    = (r_count == c_FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rd_ptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    always_ff @(posedge CLK) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ulpb_tx_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ulpb_tx_feeder
// Brief    : Queues whole messages and feeds them word by word into the
//            ping-pong data registers of a ULPB node transmitter.
// Revision : 1.0 - initial release
// ============================================================================
module ulpb_tx_feeder
    import ulpb_pkg::*;
#(
    parameter int ADDR_WIDTH  = c_ADDR_WIDTH,
    parameter int DATA_WIDTH  = c_DATA_WIDTH,
    parameter int DEPTH       = 8,
    parameter int TIMEOUT_CNT = 1024
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [ADDR_WIDTH-1:0] WR_ADDR,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    input  logic                  WR_LAST,
    input  logic                  WR_VALID,
    output logic                  WR_READY,
    output logic                  TX_REQ,
    input  logic                  TX_ACK,
    output logic [ADDR_WIDTH-1:0] TX_ADDR,
    output logic [DATA_WIDTH-1:0] TX_DATA0,
    output logic [DATA_WIDTH-1:0] TX_DATA1,
    output logic                  TX_PEND,
    input  logic                  WORD_IND,
    input  logic                  ACK_RECEIVED,
    input  logic                  TX_FAIL,
    output logic                  DONE,
    output logic                  ERR,
    output logic                  BUSY
);

    localparam int                 c_ENTRY_W   = ADDR_WIDTH + 1 + DATA_WIDTH;
    localparam int                 c_CNT_W     = $clog2(DEPTH + 1);
    localparam int                 c_TMO_W     = (TIMEOUT_CNT > 1) ? $clog2(TIMEOUT_CNT) : 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST  = c_TMO_W'(TIMEOUT_CNT - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_ENTRY_W-1:0]  w_rd_entry;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_rd_last;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [c_CNT_W-1:0]    w_fifo_count;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_flush;
    logic [c_CNT_W-1:0]    r_msg_cnt;
    logic                  r_wind_q;
    logic                  r_ack_q;
    logic                  r_fail_q;
    logic                  w_toggle;
    logic                  w_ack_rise;
    logic                  w_fail_rise;
    logic                  w_timeout;
    logic [c_TMO_W-1:0]    r_tmo_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data0;
    logic [DATA_WIDTH-1:0] r_data1;
    logic                  r_last0;
    logic                  r_last1;
    logic                  r_inflight;
    logic                  r_last_popped;
    logic                  w_new_last;
    logic                  r_done;
    logic                  r_err;
    logic                  w_ld0;
    logic                  w_ld1;
    logic                  w_swap;
    logic                  w_tmo_clr;
    logic                  w_done_set;
    logic                  w_err_set;

    ulpb_sync_fifo #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (DEPTH),
        .CNT_W (c_CNT_W)
    ) u_fifo (
        .CLK       (CLK),
        .RESET     (RESET),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_flush   (w_flush),
        .i_wr_data ({WR_ADDR, WR_LAST, WR_DATA}),
        .o_rd_data (w_rd_entry),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty),
        .o_count   (w_fifo_count)
    );

    assign w_rd_addr   = w_rd_entry[c_ENTRY_W-1 -: ADDR_WIDTH];
    assign w_rd_last   = w_rd_entry[DATA_WIDTH];
    assign w_rd_data   = w_rd_entry[DATA_WIDTH-1:0];
    assign w_push      = WR_VALID & WR_READY;
    assign w_toggle    = WORD_IND ^ r_wind_q;
    assign w_ack_rise  = ACK_RECEIVED & ~r_ack_q;
    assign w_fail_rise = TX_FAIL & ~r_fail_q;
    assign w_timeout   = (r_tmo_cnt == c_TMO_LAST);
    assign w_new_last  = r_inflight ? r_last0 : r_last1;

    assign WR_READY = ~w_fifo_full;
    assign TX_REQ   = (r_state == ST_REQ);
    assign TX_ADDR  = r_addr;
    assign TX_DATA0 = r_data0;
    assign TX_DATA1 = r_data1;
    assign TX_PEND  = ((r_state == ST_REQ) || (r_state == ST_WAIT)) &&
                      !(r_inflight ? r_last1 : r_last0);
    assign DONE     = r_done;
    assign ERR      = r_err;
    assign BUSY     = (r_state != ST_IDLE);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_flush     = 1'b0;
        w_ld0       = 1'b0;
        w_ld1       = 1'b0;
        w_swap      = 1'b0;
        w_tmo_clr   = 1'b0;
        w_done_set  = 1'b0;
        w_err_set   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                // A full FIFO holding no complete message can never drain itself.
                if ((w_fifo_count == c_DEPTH_CNT) && (r_msg_cnt == '0)) begin
                    w_flush   = 1'b1;
                    w_err_set = 1'b1;
                end else if (r_msg_cnt != '0) begin
                    w_state_nxt = ST_LOAD0;
                end
            end
            ST_LOAD0: begin
                w_pop       = 1'b1;
                w_ld0       = 1'b1;
                w_state_nxt = w_rd_last ? ST_REQ : ST_LOAD1;
            end
            ST_LOAD1: begin
                w_pop       = 1'b1;
                w_ld1       = 1'b1;
                w_state_nxt = ST_REQ;
            end
            ST_REQ: begin
                if (TX_ACK) begin
                    w_tmo_clr   = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_ack_rise) begin
                    w_done_set  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_fail_rise || (w_timeout && !w_toggle)) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = r_last_popped ? ST_IDLE : ST_DRAIN;
                end else if (w_toggle) begin
                    w_swap    = 1'b1;
                    w_tmo_clr = 1'b1;
                    // Refill the register the node just left with the next word.
                    if (!w_new_last && !r_last_popped) begin
                        w_pop = 1'b1;
                        w_ld0 = ~r_inflight;
                        w_ld1 = r_inflight;
                    end
                end
            end
            ST_DRAIN: begin
                w_pop = ~w_fifo_empty;
                if (!w_fifo_empty && w_rd_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_msg_cnt <= '0;
        end else if (w_flush) begin
            r_msg_cnt <= '0;
        end else begin
            case ({w_push & WR_LAST, w_pop & w_rd_last})
                2'b10:   r_msg_cnt <= r_msg_cnt + c_CNT_W'(1);
                2'b01:   r_msg_cnt <= r_msg_cnt - c_CNT_W'(1);
                default: r_msg_cnt <= r_msg_cnt;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_wind_q <= 1'b0;
            r_ack_q  <= 1'b0;
            r_fail_q <= 1'b0;
        end else begin
            r_wind_q <= WORD_IND;
            r_ack_q  <= ACK_RECEIVED;
            r_fail_q <= TX_FAIL;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_addr        <= '0;
            r_data0       <= '0;
            r_data1       <= '0;
            r_last0       <= 1'b0;
            r_last1       <= 1'b0;
            r_inflight    <= 1'b0;
            r_last_popped <= 1'b0;
            r_tmo_cnt     <= '0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_done <= w_done_set;
            r_err  <= w_err_set;
            if (w_ld0) begin
                r_data0 <= w_rd_data;
                r_last0 <= w_rd_last;
            end
            if (w_ld1) begin
                r_data1 <= w_rd_data;
                r_last1 <= w_rd_last;
            end
            if (r_state == ST_LOAD0) begin
                r_addr        <= w_rd_addr;
                r_inflight    <= 1'b0;
                r_last_popped <= w_rd_last;
                // Single-word message: the idle register must not look pending.
                if (w_rd_last) begin
                    r_last1 <= 1'b1;
                end
            end else if (w_pop && w_rd_last) begin
                r_last_popped <= 1'b1;
            end
            if (w_swap) begin
                r_inflight <= ~r_inflight;
            end
            if (w_tmo_clr) begin
                r_tmo_cnt <= '0;
            end else if ((r_state == ST_WAIT) && !w_timeout) begin
                r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ulpb_tx_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ulpb_tx_feeder
// Brief    : Directed and randomized message bench for ulpb_tx_feeder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ulpb_tx_feeder;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [7:0]  WR_ADDR = '0;
    logic [31:0] WR_DATA = '0;
    logic        WR_LAST = 1'b0;
    logic        WR_VALID = 1'b0;
    logic        WR_READY;
    logic        TX_REQ;
    logic        TX_ACK = 1'b0;
    logic [7:0]  TX_ADDR;
    logic [31:0] TX_DATA0;
    logic [31:0] TX_DATA1;
    logic        TX_PEND;
    logic        WORD_IND = 1'b0;
    logic        ACK_RECEIVED = 1'b0;
    logic        TX_FAIL = 1'b0;
    logic        DONE;
    logic        ERR;
    logic        BUSY;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] md [8];
    logic [7:0]  maddr;

    ulpb_tx_feeder #(
        .ADDR_WIDTH  (8),
        .DATA_WIDTH  (32),
        .DEPTH       (8),
        .TIMEOUT_CNT (1024)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .WR_ADDR      (WR_ADDR),
        .WR_DATA      (WR_DATA),
        .WR_LAST      (WR_LAST),
        .WR_VALID     (WR_VALID),
        .WR_READY     (WR_READY),
        .TX_REQ       (TX_REQ),
        .TX_ACK       (TX_ACK),
        .TX_ADDR      (TX_ADDR),
        .TX_DATA0     (TX_DATA0),
        .TX_DATA1     (TX_DATA1),
        .TX_PEND      (TX_PEND),
        .WORD_IND     (WORD_IND),
        .ACK_RECEIVED (ACK_RECEIVED),
        .TX_FAIL      (TX_FAIL),
        .DONE         (DONE),
        .ERR          (ERR),
        .BUSY         (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [7:0] a, input logic [31:0] d, input logic l);
        int n = 0;
        WR_VALID = 1'b1;
        WR_ADDR  = a;
        WR_DATA  = d;
        WR_LAST  = l;
        while (!WR_READY && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) chk("push_ready_timeout", WR_READY, 1);
        step();
        WR_VALID = 1'b0;
        WR_LAST  = 1'b0;
    endtask

    // After t node switches of an n-word message, words 0..min(t+1,n-1) have
    // been handed over; even-indexed words live in DATA0, odd ones in DATA1.
    task automatic check_regs(input int n, input int t);
        int top, j0, j1;
        top = (t + 1 < n - 1) ? t + 1 : n - 1;
        j0  = top - (top % 2);
        j1  = (top % 2 == 1) ? top : top - 1;
        chk("tx_data0", TX_DATA0, md[j0]);
        if (j1 >= 0) chk("tx_data1", TX_DATA1, md[j1]);
        chk("tx_pend", TX_PEND, (t < n - 1));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tx_req"}, TX_REQ, 0);
        chk({tag, "_tx_addr"}, TX_ADDR, 0);
        chk({tag, "_tx_data0"}, TX_DATA0, 0);
        chk({tag, "_tx_data1"}, TX_DATA1, 0);
        chk({tag, "_tx_pend"}, TX_PEND, 0);
        chk({tag, "_done"}, DONE, 0);
        chk({tag, "_err"}, ERR, 0);
        chk({tag, "_busy"}, BUSY, 0);
        chk({tag, "_wr_ready"}, WR_READY, 1);
    endtask

    task automatic push_msg(input int n);
        for (int i = 0; i < n; i++) push_word(maddr, md[i], (i == n - 1));
    endtask

    task automatic start_msg(input int n, input int hold);
        int cnt = 0;
        push_msg(n);
        while (!TX_REQ && cnt < 20) begin
            step();
            cnt++;
        end
        chk("tx_req_seen", TX_REQ, 1);
        chk("tx_addr", TX_ADDR, maddr);
        check_regs(n, 0);
        for (int i = 0; i < hold; i++) begin
            step();
            chk("tx_req_hold", TX_REQ, 1);
        end
        TX_ACK = 1'b1;
        step();
        TX_ACK = 1'b0;
        chk("tx_req_drop", TX_REQ, 0);
        chk("busy_wait", BUSY, 1);
    endtask

    task automatic run_msg(input int n, input bit fail, input int k, input int hold);
        int cnt, top, rem;
        start_msg(n, hold);
        for (int t = 1; t <= k; t++) begin
            WORD_IND = ~WORD_IND;
            step();
            check_regs(n, t);
        end
        if (!fail) begin
            ACK_RECEIVED = 1'b1;
            step();
            chk("done_pulse", DONE, 1);
            chk("err_quiet", ERR, 0);
            chk("idle_after_done", BUSY, 0);
            step();
            ACK_RECEIVED = 1'b0;
            chk("done_one_cycle", DONE, 0);
        end else begin
            top = (k + 1 < n - 1) ? k + 1 : n - 1;
            rem = n - 1 - top;
            TX_FAIL = 1'b1;
            step();
            TX_FAIL = 1'b0;
            chk("err_pulse", ERR, 1);
            chk("done_quiet", DONE, 0);
            chk("drain_entry", BUSY, (rem > 0));
            step();
            chk("err_one_cycle", ERR, 0);
            cnt = 1;
            while (BUSY && cnt < 20) begin
                step();
                cnt++;
            end
            if (rem > 0) chk("drain_cycles", cnt, rem);
            chk("idle_after_err", BUSY, 0);
        end
        chk("wr_ready_end", WR_READY, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench timeout");
    end

    initial begin
        int cnt, n;
        bit fail;

        step();
        step();
        check_reset_outputs("reset");
        RESET = 1'b0;
        step();

        // Single-word message completes with DONE.
        maddr = 8'hAB;
        md[0] = 32'h1234_5678;
        run_msg(1, 1'b0, 0, 2);

        // Four-word message walks through both ping-pong registers.
        maddr = 8'h11;
        md[0] = 32'hAAAA_0000;
        md[1] = 32'hBBBB_1111;
        md[2] = 32'hCCCC_2222;
        md[3] = 32'hDDDD_3333;
        run_msg(4, 1'b0, 3, 0);

        // Five-word message fails after one switch; two words must be drained.
        maddr = 8'h55;
        for (int i = 0; i < 5; i++) md[i] = 32'h5000_0000 + i;
        run_msg(5, 1'b1, 1, 1);

        // No node result after the ack: timeout.
        maddr = 8'h3C;
        md[0] = 32'hDEAD_BEEF;
        start_msg(1, 0);
        cnt = 0;
        while (!ERR && cnt < 1100) begin
            step();
            cnt++;
        end
        chk("timeout_cycles", cnt, 1024);
        chk("timeout_done_quiet", DONE, 0);
        chk("timeout_idle", BUSY, 0);
        step();
        chk("timeout_err_one_cycle", ERR, 0);

        // Oversize message (no last word) is flushed with ERR.
        for (int i = 0; i < 8; i++) push_word(8'h77, 32'h7700_0000 + i, 1'b0);
        chk("oversize_full", WR_READY, 0);
        cnt = 0;
        while (!ERR && cnt < 10) begin
            step();
            cnt++;
        end
        chk("oversize_err", ERR, 1);
        chk("oversize_ready", WR_READY, 1);
        chk("oversize_idle", BUSY, 0);
        step();
        chk("oversize_err_one_cycle", ERR, 0);

        // Reset while waiting with three words still queued.
        maddr = 8'h99;
        for (int i = 0; i < 5; i++) md[i] = 32'h9900_0000 + i;
        start_msg(5, 0);
        RESET = 1'b1;
        #1;
        check_reset_outputs("midreset");
        step();
        step();
        RESET = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("post_reset_done", DONE, 0);
            chk("post_reset_err", ERR, 0);
            chk("post_reset_busy", BUSY, 0);
        end

        // Randomized messages against the ping-pong model.
        for (int m = 0; m < 10; m++) begin
            n     = $urandom_range(1, 8);
            fail  = 1'($urandom_range(0, 1));
            maddr = 8'($urandom);
            for (int i = 0; i < n; i++) md[i] = $urandom;
            run_msg(n, fail, fail ? $urandom_range(0, n - 1) : n - 1, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
